// File: rtl/fpaddsub_pkg.sv
// ============================================================================
//  Module   : fpaddsub_pkg
//  Purpose  : Shared widths and payload type for the FP add/sub align stages.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpaddsub_pkg;

   localparam int MANTISSA = 10;
   localparam int EXPONENT = 5;

   typedef struct packed {
      logic [MANTISSA:0] mmax;
      logic [MANTISSA:0] mminp;
      logic [1:0]        shift;
      logic              sticky;
   } align_payload_t;

endpackage

`default_nettype wire

// File: rtl/fpaddsub_skid_buf.sv
// ============================================================================
//  Module   : fpaddsub_skid_buf
//  Purpose  : Two-entry skid buffer (main + skid) with registered ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpaddsub_skid_buf #(
   parameter type T = logic [7:0]
) (
   input  logic clk,
   input  logic rst,
   input  logic i_in_valid,
   output logic o_in_ready,
   input  T     i_in_data,
   output logic o_out_valid,
   input  logic i_out_ready,
   output T     o_out_data
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   logic [1:0] r_state;
   logic [1:0] w_state_next;
   T           r_main;
   T           r_skid;
   logic       w_accept;
   logic       w_load_main_in;
   logic       w_load_main_skid;
   logic       w_load_skid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_accept         = i_in_valid && (r_state != S_FULL);
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) begin
               w_load_main_in = 1'b1;
               w_state_next   = S_ONE;
            end
         end
         S_ONE: begin
            if (w_accept && i_out_ready) begin
               w_load_main_in = 1'b1;
            end else if (w_accept) begin
               w_load_skid  = 1'b1;
               w_state_next = S_FULL;
            end else if (i_out_ready) begin
               w_state_next = S_EMPTY;
            end
         end
         S_FULL: begin
            if (i_out_ready) begin
               w_load_main_skid = 1'b1;
               w_state_next     = S_ONE;
            end
         end
         default: begin
            w_state_next = S_EMPTY;
         end
      endcase
   end

   // Ready depends only on the state register, never on i_out_ready.
   always_comb begin
      o_out_valid = (r_state != S_EMPTY);
      o_in_ready  = (r_state != S_FULL);
      o_out_data  = r_main;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main_in) begin
            r_main <= i_in_data;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= i_in_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fpaddsub_align_coarse_stage.sv
// ============================================================================
//  Module   : fpaddsub_align_coarse_stage
//  Purpose  : Coarse multiple-of-4 alignment shift with sticky, skid-buffered.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpaddsub_align_coarse_stage #(
   parameter int MANTISSA = fpaddsub_pkg::MANTISSA,
   parameter int EXPONENT = fpaddsub_pkg::EXPONENT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MANTISSA:0]   MmaxIn,
   input  logic [MANTISSA:0]   MminIn,
   input  logic [EXPONENT-1:0] ExpDiff,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [MANTISSA:0]   Mmax,
   output logic [MANTISSA:0]   MminP,
   output logic [1:0]          Shift,
   output logic                Sticky
);

   import fpaddsub_pkg::*;

   localparam logic [EXPONENT-1:0] c_sat_limit = EXPONENT'(MANTISSA);

   logic                w_saturate;
   logic [EXPONENT-1:0] w_shamt;
   logic [MANTISSA:0]   w_mask;
   logic [MANTISSA:0]   w_mminp;
   logic [1:0]          w_shift;
   logic                w_sticky;
   align_payload_t      w_in_payload;
   align_payload_t      w_out_payload;

   // Shift by whole nibbles here; the low two bits go on to the fine stage.
   always_comb begin
      w_saturate = (ExpDiff > c_sat_limit);
      w_shamt    = {ExpDiff[EXPONENT-1:2], 2'b00};
      w_mask     = ~({(MANTISSA+1){1'b1}} << w_shamt);
      if (w_saturate) begin
         w_mminp  = '0;
         w_shift  = 2'b00;
         w_sticky = |MminIn;
      end else begin
         w_mminp  = MminIn >> w_shamt;
         w_shift  = ExpDiff[1:0];
         w_sticky = |(MminIn & w_mask);
      end
   end

   assign w_in_payload = '{mmax: MmaxIn, mminp: w_mminp, shift: w_shift, sticky: w_sticky};

   fpaddsub_skid_buf #(
      .T (align_payload_t)
   ) u_skid_buf (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (w_in_payload),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (w_out_payload)
   );

   assign Mmax   = w_out_payload.mmax;
   assign MminP  = w_out_payload.mminp;
   assign Shift  = w_out_payload.shift;
   assign Sticky = w_out_payload.sticky;

endmodule

`default_nettype wire

// File: tb/tb_fpaddsub_align_coarse_stage.sv
// ============================================================================
//  Module   : tb_fpaddsub_align_coarse_stage
//  Purpose  : Directed and randomised checks of the coarse align stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpaddsub_align_coarse_stage;

   localparam int M = 10;
   localparam int E = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [M:0]   MmaxIn;
   logic [M:0]   MminIn;
   logic [E-1:0] ExpDiff;
   logic         out_valid;
   logic         out_ready;
   logic [M:0]   Mmax;
   logic [M:0]   MminP;
   logic [1:0]   Shift;
   logic         Sticky;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fpaddsub_align_coarse_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .MmaxIn    (MmaxIn),
      .MminIn    (MminIn),
      .ExpDiff   (ExpDiff),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Mmax      (Mmax),
      .MminP     (MminP),
      .Shift     (Shift),
      .Sticky    (Sticky)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [M:0] mx, input logic [M:0] mn, input logic [E-1:0] ed);
      in_valid = 1'b1;
      MmaxIn   = mx;
      MminIn   = mn;
      ExpDiff  = ed;
   endtask

   task automatic chk_out(input string tag, input logic [M:0] mx, input logic [M:0] mp,
                          input logic [1:0] sh, input logic st);
      check({tag, "_valid"},  32'(out_valid), 32'd1);
      check({tag, "_mmax"},   32'(Mmax),      32'(mx));
      check({tag, "_mminp"},  32'(MminP),     32'(mp));
      check({tag, "_shift"},  32'(Shift),     32'(sh));
      check({tag, "_sticky"}, 32'(Sticky),    32'(st));
   endtask

   function automatic logic [24:0] model(input logic [M:0] mx, input logic [M:0] mn,
                                         input logic [E-1:0] ed);
      logic [M:0] r;
      logic [1:0] s2;
      logic       st;
      int         e;
      int         sh;
      e  = int'(ed);
      st = 1'b0;
      if (e > M) begin
         r  = '0;
         s2 = 2'b00;
         for (int i = 0; i <= M; i++) st = st | mn[i];
      end else begin
         sh = 4 * (e / 4);
         r  = mn >> sh;
         s2 = 2'(e % 4);
         for (int i = 0; i <= M; i++) if (i < sh) st = st | mn[i];
      end
      return {mx, r, s2, st};
   endfunction

   logic [24:0] q[$];
   logic [24:0] held;
   logic [24:0] got;
   logic        was_stall;
   int          transfers;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      MmaxIn    = '0;
      MminIn    = '0;
      ExpDiff   = '0;
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_payload",   32'({Mmax, MminP, Shift, Sticky}), 32'd0);
      rst = 1'b0;

      // directed shift/sticky vectors, output always ready
      out_ready = 1'b1;
      drive(11'h5A5, 11'h7FF, 5'd5);  step(); chk_out("ed5",    11'h5A5, 11'h07F, 2'd1, 1'b1);
      drive(11'h0A1, 11'h400, 5'd8);  step(); chk_out("ed8",    11'h0A1, 11'h004, 2'd0, 1'b0);
      drive(11'h0A2, 11'h400, 5'd0);  step(); chk_out("ed0",    11'h0A2, 11'h400, 2'd0, 1'b0);
      drive(11'h0A3, 11'h001, 5'd12); step(); chk_out("sat1",   11'h0A3, 11'h000, 2'd0, 1'b1);
      drive(11'h0A4, 11'h000, 5'd12); step(); chk_out("sat0",   11'h0A4, 11'h000, 2'd0, 1'b0);
      drive(11'h0A5, 11'h7FF, 5'd10); step(); chk_out("ed10",   11'h0A5, 11'h007, 2'd2, 1'b1);
      drive(11'h0A6, 11'h7FF, 5'd11); step(); chk_out("ed11",   11'h0A6, 11'h000, 2'd0, 1'b1);
      drive(11'h0A7, 11'h00F, 5'd3);  step(); chk_out("ed3",    11'h0A7, 11'h00F, 2'd3, 1'b0);
      drive(11'h0A8, 11'h010, 5'd31); step(); chk_out("ed31",   11'h0A8, 11'h000, 2'd0, 1'b1);
      in_valid = 1'b0;
      MminIn   = 11'h7FF;
      step();
      check("idle_out_valid", 32'(out_valid), 32'd0);

      // backpressure: A and B accepted, C held off until space frees
      out_ready = 1'b0;
      drive(11'h111, 11'h7FF, 5'd5); step();
      chk_out("bpA", 11'h111, 11'h07F, 2'd1, 1'b1);
      check("bpA_in_ready", 32'(in_ready), 32'd1);
      drive(11'h222, 11'h400, 5'd8); step();
      check("bpB_in_ready", 32'(in_ready), 32'd0);
      chk_out("bpB_holdA", 11'h111, 11'h07F, 2'd1, 1'b1);
      drive(11'h333, 11'h0F0, 5'd6); step();
      check("bpC_in_ready", 32'(in_ready), 32'd0);
      chk_out("bpC_holdA", 11'h111, 11'h07F, 2'd1, 1'b1);
      out_ready = 1'b1;
      step();
      chk_out("drainB", 11'h222, 11'h004, 2'd0, 1'b0);
      check("drainB_in_ready", 32'(in_ready), 32'd1);
      step();
      chk_out("drainC", 11'h333, 11'h00F, 2'd2, 1'b0);
      in_valid = 1'b0;
      step();
      check("drain_empty", 32'(out_valid), 32'd0);

      // reset while full discards both entries
      out_ready = 1'b0;
      drive(11'h444, 11'h123, 5'd3); step();
      drive(11'h555, 11'h321, 5'd4); step();
      check("full_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_payload",   32'({Mmax, MminP, Shift, Sticky}), 32'd0);
      out_ready = 1'b1;
      step();
      step();
      step();
      check("midrst_no_ghost", 32'(out_valid), 32'd0);

      // randomised traffic against a scoreboard
      was_stall = 1'b0;
      held      = '0;
      transfers = 0;
      for (int c = 0; c < 40000 && transfers < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         MmaxIn    = 11'($urandom);
         MminIn    = 11'($urandom);
         ExpDiff   = 5'($urandom);
         @(negedge clk);
         got = {Mmax, MminP, Shift, Sticky};
         if (was_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  32'(got),       32'(held));
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("sb_data", 32'(got), 32'(q.pop_front()));
            transfers++;
         end
         if (in_valid && in_ready) q.push_back(model(MmaxIn, MminIn, ExpDiff));
         was_stall = out_valid && !out_ready;
         held      = got;
         step();
      end
      check("sb_transfers", 32'(transfers >= 10000), 32'd1);

      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid) begin
            check("drain_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("drain_data", 32'({Mmax, MminP, Shift, Sticky}), 32'(q.pop_front()));
         end
         step();
      end
      check("sb_final_empty", 32'(q.size()), 32'd0);
      check("final_idle",     32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
